hdc_argmin_search: RTL

- Associative-memory search controller. Sits directly downstream of the Hamming-distance stage.
- Per query: sweeps class addresses 0..NUM_CLASS-1 into the class-hypervector memory, receives one distance per class from the distance stage after a fixed pipeline latency, and tracks the running minimum.
- Returns the predicted class index and its distance over a valid/ready result port.

---
 rtl/hdc_pkg.sv | 28 ++
 rtl/hdc_argmin_search_if.sv | 27 ++
 rtl/hdc_tag_pipe.sv | 38 +++
 rtl/hdc_argmin_search.sv | 129 ++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// Shared constants, width helpers and search-state encoding for the HDC
// associative-memory search blocks.
package hdc_pkg;

    localparam int DIM_DEF       = 1024;
    localparam int NUM_CLASS_DEF = 26;
    localparam int LAT_DEF       = 2;

    // A single class still needs a one-bit index so ports never collapse to zero width.
    function automatic int cls_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int dist_width(input int d);
        return $clog2(d) + 1;
    endfunction

    localparam int DIST_W = dist_width(DIM_DEF);
    localparam int CLS_W  = cls_width(NUM_CLASS_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } search_state_t;

endpackage

// File: rtl/hdc_argmin_search_if.sv
// Start, class-memory read and result handshakes of the argmin search controller.
interface hdc_argmin_search_if
    import hdc_pkg::*;
#(
    parameter int CLS_W  = hdc_pkg::CLS_W,
    parameter int DIST_W = hdc_pkg::DIST_W
);
    logic              start;
    logic              start_ready;
    logic              class_rd_en;
    logic [CLS_W-1:0]  class_addr;
    logic [DIST_W-1:0] simi;
    logic              res_valid;
    logic              res_ready;
    logic [CLS_W-1:0]  res_class;
    logic [DIST_W-1:0] res_dist;

    modport master (
        input  start, simi, res_ready,
        output start_ready, class_rd_en, class_addr, res_valid, res_class, res_dist
    );

    modport slave (
        output start, simi, res_ready,
        input  start_ready, class_rd_en, class_addr, res_valid, res_class, res_dist
    );
endinterface

// File: rtl/hdc_tag_pipe.sv
// Fixed-latency delay line carrying {valid, index} alongside a pipelined read,
// so the returning data can be matched to the request that produced it.
module hdc_tag_pipe #(
    parameter int LAT   = 2,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic [LAT-1:0]   vld_r;
    logic [IDX_W-1:0] idx_r [LAT];

    // Shift every cycle; reset discards every in-flight tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_r <= {LAT{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                idx_r[i] <= {IDX_W{1'b0}};
            end
        end else begin
            vld_r[0] <= in_valid;
            idx_r[0] <= in_idx;
            for (int i = 1; i < LAT; i++) begin
                vld_r[i] <= vld_r[i-1];
                idx_r[i] <= idx_r[i-1];
            end
        end
    end

    assign out_valid = vld_r[LAT-1];
    assign out_idx   = idx_r[LAT-1];

endmodule

// File: rtl/hdc_argmin_search.sv
// Sweeps all class addresses per query, tracks the minimum returned distance
// and presents the winning class over a valid/ready result port.
module hdc_argmin_search
    import hdc_pkg::*;
#(
    parameter int DIM       = DIM_DEF,
    parameter int NUM_CLASS = NUM_CLASS_DEF,
    parameter int LAT       = LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    hdc_argmin_search_if.master bus
);

    localparam int CW = cls_width(NUM_CLASS);
    localparam int DW = dist_width(DIM);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CLASS - 1);

    search_state_t state_r;
    logic          start_ready_r;
    logic          class_rd_en_r;
    logic [CW-1:0] class_addr_r;
    logic          res_valid_r;
    logic [CW-1:0] res_class_r;
    logic [DW-1:0] res_dist_r;
    logic [DW-1:0] min_r;
    logic [CW-1:0] best_r;

    logic          tag_valid_s;
    logic [CW-1:0] tag_idx_s;
    logic          upd_s;
    logic          last_s;
    logic [DW-1:0] min_nxt_s;
    logic [CW-1:0] best_nxt_s;

    hdc_tag_pipe #(
        .LAT   (LAT),
        .IDX_W (CW)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (class_rd_en_r),
        .in_idx    (class_addr_r),
        .out_valid (tag_valid_s),
        .out_idx   (tag_idx_s)
    );

    // Strict less-than keeps the earliest index on ties.
    always_comb begin
        upd_s  = tag_valid_s && (bus.simi < min_r);
        last_s = tag_valid_s && (tag_idx_s == LAST_IDX);
        if (upd_s) begin
            min_nxt_s  = bus.simi;
            best_nxt_s = tag_idx_s;
        end else begin
            min_nxt_s  = min_r;
            best_nxt_s = best_r;
        end
    end

    // Search FSM with registered handshake, read-strobe and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            start_ready_r <= 1'b1;
            class_rd_en_r <= 1'b0;
            class_addr_r  <= {CW{1'b0}};
            res_valid_r   <= 1'b0;
            res_class_r   <= {CW{1'b0}};
            res_dist_r    <= {DW{1'b0}};
            min_r         <= {DW{1'b1}};
            best_r        <= {CW{1'b0}};
        end else begin
            min_r  <= min_nxt_s;
            best_r <= best_nxt_s;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_r       <= ISSUE;
                        start_ready_r <= 1'b0;
                        class_rd_en_r <= 1'b1;
                        class_addr_r  <= {CW{1'b0}};
                        min_r         <= {DW{1'b1}};
                        best_r        <= {CW{1'b0}};
                    end
                end
                ISSUE: begin
                    if (class_addr_r == LAST_IDX) begin
                        state_r       <= DRAIN;
                        class_rd_en_r <= 1'b0;
                        class_addr_r  <= {CW{1'b0}};
                    end else begin
                        class_addr_r  <= class_addr_r + CW'(1);
                    end
                end
                DRAIN: begin
                    // The final tag is compared this cycle, so latch the post-compare result.
                    if (last_s) begin
                        state_r     <= DONE;
                        res_valid_r <= 1'b1;
                        res_class_r <= best_nxt_s;
                        res_dist_r  <= min_nxt_s;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state_r       <= IDLE;
                        res_valid_r   <= 1'b0;
                        start_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    start_ready_r <= 1'b1;
                    class_rd_en_r <= 1'b0;
                    res_valid_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start_ready = start_ready_r;
    assign bus.class_rd_en = class_rd_en_r;
    assign bus.class_addr  = class_addr_r;
    assign bus.res_valid   = res_valid_r;
    assign bus.res_class   = res_class_r;
    assign bus.res_dist    = res_dist_r;

endmodule
